// File: rtl/fuec_pkg.sv
// Shared definitions for the FUEC (12,8) code: widths, codeword slicing and
// the parity-check columns, used by both the encoder stream and the decoder.
package fuec_pkg;

    localparam int DATA_W   = 8;
    localparam int PAR_W    = 4;
    localparam int CW_W     = 12;
    localparam int DATA_LSB = 0;
    localparam int PAR_LSB  = 8;

    typedef logic [CW_W-1:0]   fuec_cw_t;
    typedef logic [DATA_W-1:0] fuec_data_t;
    typedef logic [PAR_W-1:0]  fuec_par_t;

    // Syndrome column of each data bit; all distinct with weight >= 2, so a
    // single flipped bit anywhere in the codeword maps to a unique syndrome.
    localparam logic [DATA_W-1:0][PAR_W-1:0] FUEC_H_COL = {
        4'b1011, 4'b0111, 4'b1100, 4'b1010,
        4'b1001, 4'b0110, 4'b0101, 4'b0011
    };

endpackage

// File: rtl/fuec_encoder_12_8.sv
// Combinational FUEC (12,8) parity core: parity is the XOR of the syndrome
// columns of every set data bit.
module fuec_encoder_12_8
    import fuec_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [PAR_W-1:0]  parity
);

    // NOTE: combinational blocks assign a default first and use blocking
    // assignments, so every path drives the output and no latch is inferred.
    always_comb begin
        parity = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                parity = parity ^ FUEC_H_COL[i];
            end
        end
    end

endmodule

// File: rtl/fuec_encoder_stream.sv
// Streaming FUEC (12,8) encoder: registered output stage plus one-word skid
// buffer, codeword counter, and optional fault injection (FUEC_ERR_INJECT_EN).
module fuec_encoder_stream
    import fuec_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CW_W-1:0]    m_cw,
    output logic [COUNT_W-1:0] cw_count
`ifdef FUEC_ERR_INJECT_EN
    ,
    input  logic               inj_arm,
    input  logic [CW_W-1:0]    inj_mask,
    output logic               inj_pending,
    output logic [7:0]         inj_count
`endif
);

    logic               s_ready_q,    s_ready_d;
    logic               m_valid_q,    m_valid_d;
    fuec_cw_t           m_cw_q,       m_cw_d;
    logic               skid_valid_q, skid_valid_d;
    fuec_data_t         skid_data_q,  skid_data_d;
    logic [COUNT_W-1:0] cw_count_q,   cw_count_d;

    logic       s_fire;
    logic       m_fire;
    logic       load;
    fuec_data_t src_data;
    fuec_par_t  parity;
    fuec_cw_t   cw_clean;
    fuec_cw_t   cw_load;

    // Reset gates s_ready directly so nothing is accepted while it is held.
    assign s_ready  = s_ready_q && !rst;
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid_q && m_ready;
    assign src_data = skid_valid_q ? skid_data_q : s_data;
    assign load     = (!m_valid_q || m_ready) && (skid_valid_q || s_fire);

    fuec_encoder_12_8 u_enc (
        .data   (src_data),
        .parity (parity)
    );

    always_comb begin
        cw_clean                       = '0;
        cw_clean[DATA_LSB +: DATA_W]   = src_data;
        cw_clean[PAR_LSB  +: PAR_W]    = parity;
    end

`ifdef FUEC_ERR_INJECT_EN
    logic       inj_pending_q, inj_pending_d;
    fuec_cw_t   inj_mask_q,    inj_mask_d;
    logic [7:0] inj_count_q,   inj_count_d;

    // The load consumes the mask armed earlier; an arm in the same cycle
    // is recorded for the following load.
    always_comb begin
        inj_pending_d = inj_pending_q;
        inj_mask_d    = inj_mask_q;
        inj_count_d   = inj_count_q;
        cw_load       = cw_clean;
        if (load && inj_pending_q) begin
            cw_load       = cw_clean ^ inj_mask_q;
            inj_pending_d = 1'b0;
            inj_count_d   = inj_count_q + 8'd1;
        end
        if (inj_arm) begin
            inj_pending_d = 1'b1;
            inj_mask_d    = inj_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pending_q <= 1'b0;
            inj_mask_q    <= '0;
            inj_count_q   <= '0;
        end else begin
            inj_pending_q <= inj_pending_d;
            inj_mask_q    <= inj_mask_d;
            inj_count_q   <= inj_count_d;
        end
    end

    assign inj_pending = inj_pending_q;
    assign inj_count   = inj_count_q;
`else
    assign cw_load = cw_clean;
`endif

    always_comb begin
        m_valid_d    = m_valid_q;
        m_cw_d       = m_cw_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        cw_count_d   = cw_count_q;

        if (load) begin
            m_valid_d    = 1'b1;
            m_cw_d       = cw_load;
            skid_valid_d = 1'b0;
        end else if (m_fire) begin
            m_valid_d = 1'b0;
        end

        // s_fire implies the skid is empty, so capture never collides with a drain.
        if (s_fire && m_valid_q && !m_ready) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end

        if (m_fire) begin
            cw_count_d = cw_count_q + COUNT_W'(1);
        end

        s_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_cw_q       <= '0;
            skid_valid_q <= 1'b0;
            cw_count_q   <= '0;
        end else begin
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_cw_q       <= m_cw_d;
            skid_valid_q <= skid_valid_d;
            cw_count_q   <= cw_count_d;
        end
    end

    // NOTE: skid data is qualified by skid_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    assign m_valid  = m_valid_q;
    assign m_cw     = m_cw_q;
    assign cw_count = cw_count_q;

endmodule
